// File: rtl/pong_ball_engine.sv
// rtl/pong_ball_engine.sv - per-frame ball movement, collision and scoring engine
// Ball/score state advances on frame_tick; all outputs come straight from registers.
module pong_ball_engine #(
  parameter int COORD_W     = 10,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_L_X  = 16,
  parameter int PADDLE_R_X  = 616,
  parameter int SPEED       = 2,
  parameter int SERVE_X     = 316,
  parameter int SERVE_Y     = 236,
  parameter int HOLD_FRAMES = 60,
  parameter int SCORE_MAX   = 9
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic               serve,
  input  logic               clear_scores,
  input  logic [COORD_W-1:0] paddle_l_y,
  input  logic [COORD_W-1:0] paddle_r_y,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [3:0]         score_l,
  output logic [3:0]         score_r,
  output logic               hit,
  output logic               miss,
  output logic               game_over,
  output logic [1:0]         state_o
);
  localparam int AW    = COORD_W + 1;
  localparam int CNT_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [AW-1:0] E_SPD  = AW'(SPEED);
  localparam logic [AW-1:0] E_BS   = AW'(BALL_SIZE);
  localparam logic [AW-1:0] E_PH   = AW'(PADDLE_H);
  localparam logic [AW-1:0] E_YMAX = AW'(SCREEN_H - BALL_SIZE);
  localparam logic [AW-1:0] E_XMAX = AW'(SCREEN_W - BALL_SIZE);
  localparam logic [AW-1:0] E_PRX  = AW'(PADDLE_R_X);
  localparam logic [AW-1:0] E_PLE  = AW'(PADDLE_L_X + PADDLE_W);
  localparam logic [COORD_W-1:0] SX     = COORD_W'(SERVE_X);
  localparam logic [COORD_W-1:0] SY     = COORD_W'(SERVE_Y);
  localparam logic [COORD_W-1:0] R_STOP = COORD_W'(PADDLE_R_X - BALL_SIZE);
  localparam logic [COORD_W-1:0] L_STOP = COORD_W'(PADDLE_L_X + PADDLE_W);
  localparam logic [COORD_W-1:0] Y_BOT  = COORD_W'(SCREEN_H - BALL_SIZE);
  localparam logic [3:0]         SMAX   = 4'(SCORE_MAX);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MOVE = 2'd1, S_HOLD = 2'd2, S_OVER = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               dx_q, dx_d, dy_q, dy_d;   // dx 1 = right, dy 1 = down
  logic [3:0]         sl_q, sl_d, sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hit_q, hit_d, miss_q, miss_d;

  logic [AW-1:0] x_e, y_e, pl_e, pr_e;
  logic          ovl_l, ovl_r, r_hit, r_miss, l_hit, l_miss;

  assign x_e  = {1'b0, x_q};
  assign y_e  = {1'b0, y_q};
  assign pl_e = {1'b0, paddle_l_y};
  assign pr_e = {1'b0, paddle_r_y};

  assign ovl_l  = (y_e + E_BS > pl_e) && (y_e < pl_e + E_PH);
  assign ovl_r  = (y_e + E_BS > pr_e) && (y_e < pr_e + E_PH);
  assign r_hit  = (x_e + E_BS <= E_PRX) && (x_e + E_BS + E_SPD >= E_PRX) && ovl_r;
  assign r_miss = (x_e + E_SPD > E_XMAX);
  assign l_hit  = (x_e >= E_PLE) && (x_e - E_SPD <= E_PLE) && ovl_l;
  assign l_miss = (x_e < E_SPD);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    if (clear_scores) begin
      state_d = S_IDLE;
      x_d     = SX;
      y_d     = SY;
      dx_d    = 1'b1;
      dy_d    = 1'b1;
      sl_d    = 4'd0;
      sr_d    = 4'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (serve && enable) state_d = S_MOVE;
        S_MOVE: if (frame_tick && enable) begin
          if (dy_q && (y_e + E_SPD >= E_YMAX)) begin
            y_d  = Y_BOT;
            dy_d = 1'b0;
          end else if (!dy_q && (y_e <= E_SPD)) begin
            y_d  = '0;
            dy_d = 1'b1;
          end else begin
            y_d = dy_q ? y_q + COORD_W'(SPEED) : y_q - COORD_W'(SPEED);
          end
          if (dx_q) begin
            if (r_hit) begin
              x_d   = R_STOP;
              dx_d  = 1'b0;
              hit_d = 1'b1;
            end else if (r_miss) begin
              miss_d = 1'b1;
              dx_d   = 1'b0;
              if (sl_q < SMAX) sl_d = sl_q + 4'd1;
            end else begin
              x_d = x_q + COORD_W'(SPEED);
            end
          end else begin
            if (l_hit) begin
              x_d   = L_STOP;
              dx_d  = 1'b1;
              hit_d = 1'b1;
            end else if (l_miss) begin
              miss_d = 1'b1;
              dx_d   = 1'b1;
              if (sr_q < SMAX) sr_d = sr_q + 4'd1;
            end else begin
              x_d = x_q - COORD_W'(SPEED);
            end
          end
          // A point re-centres the ball and throws away this tick's vertical step.
          if (miss_d) begin
            x_d     = SX;
            y_d     = SY;
            dy_d    = dy_q;
            cnt_d   = '0;
            state_d = (sl_d == SMAX || sr_d == SMAX) ? S_OVER : S_HOLD;
          end
        end
        S_HOLD: if (frame_tick) begin
          if (cnt_q == CNT_W'(HOLD_FRAMES - 1)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      x_q    <= SX;
      y_q    <= SY;
      dx_q   <= 1'b1;
      dy_q   <= 1'b1;
      sl_q   <= 4'd0;
      sr_q   <= 4'd0;
      cnt_q  <= '0;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      dx_q   <= dx_d;
      dy_q   <= dy_d;
      sl_q   <= sl_d;
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  always_comb begin
    ball_x    = x_q;
    ball_y    = y_q;
    score_l   = sl_q;
    score_r   = sr_q;
    hit       = hit_q;
    miss      = miss_q;
    game_over = (state_q == S_OVER);
    state_o   = state_q;
  end
endmodule

// File: tb/tb_pong_ball_engine.sv
// tb/tb_pong_ball_engine.sv - self-checking bench for pong_ball_engine
// A reference model pushes the expected post-tick view onto a queue; each test pops and compares.
module tb_pong_ball_engine;
  logic       ACLK = 1'b0;
  logic       ARESET, frame_tick, enable, serve, clear_scores;
  logic [9:0] paddle_l_y, paddle_r_y, ball_x, ball_y;
  logic [3:0] score_l, score_r;
  logic       hit, miss, game_over;
  logic [1:0] state_o;

  pong_ball_engine dut (
    .ACLK(ACLK), .ARESET(ARESET), .frame_tick(frame_tick), .enable(enable),
    .serve(serve), .clear_scores(clear_scores), .paddle_l_y(paddle_l_y),
    .paddle_r_y(paddle_r_y), .ball_x(ball_x), .ball_y(ball_y), .score_l(score_l),
    .score_r(score_r), .hit(hit), .miss(miss), .game_over(game_over), .state_o(state_o)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [9:0] x; logic [9:0] y; logic [3:0] sl; logic [3:0] sr;
    logic hit; logic miss; logic over; logic [1:0] st;
  } obs_t;

  obs_t sb[$];
  int   tests, fails;
  int   m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_st, m_cnt, m_hit, m_miss;
  bit   track_l, dodge_r;

  function automatic obs_t sample();
    return '{x: ball_x, y: ball_y, sl: score_l, sr: score_r, hit: hit, miss: miss,
             over: game_over, st: state_o};
  endfunction

  function automatic obs_t model_obs();
    return '{x: 10'(m_x), y: 10'(m_y), sl: 4'(m_sl), sr: 4'(m_sr), hit: m_hit[0],
             miss: m_miss[0], over: (m_st == 3), st: 2'(m_st)};
  endfunction

  function automatic bit ovl(int y, int py);
    return (y + 8 > py) && (y < py + 64);
  endfunction

  task automatic model_reset();
    m_x = 316; m_y = 236; m_dx = 1; m_dy = 1; m_sl = 0; m_sr = 0;
    m_st = 0; m_cnt = 0; m_hit = 0; m_miss = 0;
  endtask

  task automatic model_step();
    int ny, ndy;
    m_hit = 0; m_miss = 0;
    if (m_st == 1 && enable) begin
      if (m_dy > 0 && m_y + 2 >= 472) begin ny = 472; ndy = -1; end
      else if (m_dy < 0 && m_y <= 2) begin ny = 0; ndy = 1; end
      else begin ny = m_y + 2 * m_dy; ndy = m_dy; end
      if (m_dx > 0) begin
        if (m_x + 8 <= 616 && m_x + 10 >= 616 && ovl(m_y, int'(paddle_r_y))) begin
          m_x = 608; m_dx = -1; m_hit = 1;
        end else if (m_x + 2 > 632) begin
          m_miss = 1; m_dx = -1; if (m_sl < 9) m_sl++;
        end else m_x += 2;
      end else begin
        if (m_x >= 24 && m_x - 2 <= 24 && ovl(m_y, int'(paddle_l_y))) begin
          m_x = 24; m_dx = 1; m_hit = 1;
        end else if (m_x < 2) begin
          m_miss = 1; m_dx = 1; if (m_sr < 9) m_sr++;
        end else m_x -= 2;
      end
      if (m_miss) begin
        m_x = 316; m_y = 236; m_cnt = 0;
        m_st = (m_sl == 9 || m_sr == 9) ? 3 : 2;
      end else begin
        m_y = ny; m_dy = ndy;
      end
    end else if (m_st == 2) begin
      m_cnt++;
      if (m_cnt == 60) begin m_cnt = 0; m_st = 0; end
    end
  endtask

  task automatic tick();
    if (track_l) paddle_l_y = 10'(m_y);
    if (dodge_r) paddle_r_y = (m_y >= 200) ? 10'd0 : 10'd400;
    model_step();
    sb.push_back(model_obs());
    @(negedge ACLK); frame_tick = 1'b1;
    @(negedge ACLK); frame_tick = 1'b0;
  endtask

  task automatic do_serve();
    @(negedge ACLK); serve = 1'b1;
    if (m_st == 0 && enable) m_st = 1;
    m_hit = 0; m_miss = 0;
    @(negedge ACLK); serve = 1'b0;
  endtask

  task automatic do_reset();
    frame_tick = 0; serve = 0; clear_scores = 0; enable = 1;
    track_l = 0; dodge_r = 0; paddle_l_y = 10'd0; paddle_r_y = 10'd0;
    @(negedge ACLK); #2 ARESET = 1'b1; model_reset();
    @(negedge ACLK); ARESET = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    obs_t got, exp;
    ARESET = 1'b1; frame_tick = 0; serve = 0; clear_scores = 0; enable = 1;
    paddle_l_y = 0; paddle_r_y = 0; model_reset();
    repeat (3) @(negedge ACLK);
    got = sample(); exp = '{x: 10'd316, y: 10'd236, sl: 4'd0, sr: 4'd0, hit: 1'b0, miss: 1'b0, over: 1'b0, st: 2'd0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL reset_state got %p exp %p", got, exp); end
    @(negedge ACLK); ARESET = 1'b0;
  endtask

  task automatic test_first_tick();
    obs_t got, exp;
    do_reset(); do_serve(); tick();
    got = sample(); exp = sb.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL first_tick_sb got %p exp %p", got, exp); end
    tests++;
    if (ball_x !== 10'd318 || ball_y !== 10'd238 || state_o !== 2'd1) begin
      fails++; $display("FAIL first_tick got (%0d,%0d) st %0d exp (318,238) st 1", ball_x, ball_y, state_o);
    end
  endtask

  task automatic test_wall_bounce();
    obs_t got, exp;
    do_reset(); do_serve();
    for (int i = 1; i <= 119; i++) begin
      tick(); got = sample(); exp = sb.pop_front(); tests++;
      if (got !== exp) begin fails++; $display("FAIL bounce_sb tick %0d got %p exp %p", i, got, exp); end
      if (i == 118) begin
        tests++;
        if (ball_y !== 10'd472) begin fails++; $display("FAIL bounce_y118 got %0d exp 472", ball_y); end
      end
    end
    tests++;
    if (ball_x !== 10'd554 || ball_y !== 10'd470) begin
      fails++; $display("FAIL bounce_t119 got (%0d,%0d) exp (554,470)", ball_x, ball_y);
    end
  endtask

  task automatic test_paddle_hit();
    obs_t got, exp;
    do_reset(); paddle_r_y = 10'd400; do_serve();
    for (int i = 1; i <= 147; i++) begin
      tick(); got = sample(); exp = sb.pop_front(); tests++;
      if (got !== exp) begin fails++; $display("FAIL hit_sb tick %0d got %p exp %p", i, got, exp); end
      if (i == 146) begin
        tests++;
        if (ball_x !== 10'd608 || hit !== 1'b1 || ball_y !== 10'd416) begin
          fails++; $display("FAIL hit_t146 got x=%0d hit=%0b y=%0d exp x=608 hit=1 y=416", ball_x, hit, ball_y);
        end
      end
    end
    tests++;
    if (ball_x !== 10'd606 || hit !== 1'b0) begin
      fails++; $display("FAIL hit_t147 got x=%0d hit=%0b exp x=606 hit=0", ball_x, hit);
    end
  endtask

  task automatic test_miss_hold();
    obs_t got, exp;
    do_reset(); paddle_r_y = 10'd0; do_serve();
    for (int i = 1; i <= 159; i++) begin
      tick(); got = sample(); exp = sb.pop_front(); tests++;
      if (got !== exp) begin fails++; $display("FAIL miss_sb tick %0d got %p exp %p", i, got, exp); end
      if (i == 158) begin
        tests++;
        if (ball_x !== 10'd632) begin fails++; $display("FAIL miss_t158 got x=%0d exp 632", ball_x); end
      end
    end
    tests++;
    if (miss !== 1'b1 || score_l !== 4'd1 || ball_x !== 10'd316 || ball_y !== 10'd236 || state_o !== 2'd2) begin
      fails++; $display("FAIL miss_t159 got miss=%0b sl=%0d (%0d,%0d) st=%0d exp 1 1 (316,236) 2",
                        miss, score_l, ball_x, ball_y, state_o);
    end
    for (int k = 1; k <= 60; k++) begin
      if (k == 30) begin
        do_serve(); tests++;
        if (state_o !== 2'd2) begin fails++; $display("FAIL serve_in_hold got st=%0d exp 2", state_o); end
      end
      tick(); got = sample(); exp = sb.pop_front(); tests++;
      if (got !== exp) begin fails++; $display("FAIL hold_sb tick %0d got %p exp %p", k, got, exp); end
    end
    tests++;
    if (state_o !== 2'd0) begin fails++; $display("FAIL hold_exit got st=%0d exp 0", state_o); end
    do_serve(); tick(); got = sample(); exp = sb.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL reserve_sb got %p exp %p", got, exp); end
    tests++;
    if (ball_x !== 10'd314) begin fails++; $display("FAIL reserve_left got x=%0d exp 314", ball_x); end
  endtask

  task automatic test_game_over();
    obs_t got, exp;
    int guard;
    do_reset(); track_l = 1; dodge_r = 1;
    for (int p = 0; p < 9; p++) begin
      do_serve();
      guard = 0;
      while (m_st == 1 && guard < 2000) begin
        tick(); got = sample(); exp = sb.pop_front(); tests++; guard++;
        if (got !== exp) begin fails++; $display("FAIL over_sb pt %0d got %p exp %p", p, got, exp); end
      end
      if (m_st == 2) begin
        for (int k = 0; k < 60; k++) begin
          tick(); got = sample(); exp = sb.pop_front(); tests++;
          if (got !== exp) begin fails++; $display("FAIL over_hold_sb pt %0d got %p exp %p", p, got, exp); end
        end
      end
    end
    tests++;
    if (score_l !== 4'd9 || game_over !== 1'b1 || state_o !== 2'd3) begin
      fails++; $display("FAIL game_over got sl=%0d go=%0b st=%0d exp 9 1 3", score_l, game_over, state_o);
    end
    do_serve(); tick(); got = sample(); exp = sb.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL over_frozen_sb got %p exp %p", got, exp); end
    tests++;
    if (state_o !== 2'd3 || score_l !== 4'd9) begin
      fails++; $display("FAIL over_serve_ignored got st=%0d sl=%0d exp 3 9", state_o, score_l);
    end
    @(negedge ACLK); clear_scores = 1'b1; model_reset();
    @(negedge ACLK); clear_scores = 1'b0;
    got = sample(); exp = model_obs(); tests++;
    if (got !== exp) begin fails++; $display("FAIL clear_scores got %p exp %p", got, exp); end
  endtask

  task automatic test_enable_freeze();
    obs_t got, exp;
    do_reset(); do_serve();
    for (int i = 1; i <= 11; i++) begin
      enable = (i >= 6 && i <= 10) ? 1'b0 : 1'b1;
      tick(); got = sample(); exp = sb.pop_front(); tests++;
      if (got !== exp) begin fails++; $display("FAIL freeze_sb tick %0d got %p exp %p", i, got, exp); end
      if (i == 10) begin
        tests++;
        if (ball_x !== 10'd326 || ball_y !== 10'd246 || state_o !== 2'd1) begin
          fails++; $display("FAIL freeze_hold got (%0d,%0d) st=%0d exp (326,246) 1", ball_x, ball_y, state_o);
        end
      end
    end
    tests++;
    if (ball_x !== 10'd328 || ball_y !== 10'd248) begin
      fails++; $display("FAIL freeze_resume got (%0d,%0d) exp (328,248)", ball_x, ball_y);
    end
  endtask

  task automatic test_clear_vs_tick();
    obs_t got, exp;
    do_reset(); do_serve();
    repeat (3) begin
      tick(); got = sample(); exp = sb.pop_front(); tests++;
      if (got !== exp) begin fails++; $display("FAIL clr_tick_sb got %p exp %p", got, exp); end
    end
    @(negedge ACLK); clear_scores = 1'b1; frame_tick = 1'b1; model_reset();
    @(negedge ACLK); clear_scores = 1'b0; frame_tick = 1'b0;
    got = sample(); exp = model_obs(); tests++;
    if (got !== exp) begin fails++; $display("FAIL clear_priority got %p exp %p", got, exp); end
  endtask

  task automatic test_reset_in_hold();
    obs_t got, exp;
    do_reset(); paddle_r_y = 10'd0; do_serve();
    for (int i = 1; i <= 169; i++) begin
      tick(); got = sample(); exp = sb.pop_front(); tests++;
      if (got !== exp) begin fails++; $display("FAIL rhold_sb tick %0d got %p exp %p", i, got, exp); end
    end
    tests++;
    if (state_o !== 2'd2 || score_l !== 4'd1) begin
      fails++; $display("FAIL rhold_pre got st=%0d sl=%0d exp 2 1", state_o, score_l);
    end
    #2 ARESET = 1'b1; model_reset();
    #1 got = sample(); exp = model_obs(); tests++;
    if (got !== exp) begin fails++; $display("FAIL async_reset got %p exp %p", got, exp); end
    @(negedge ACLK); ARESET = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_first_tick();
    test_wall_bounce();
    test_paddle_hit();
    test_miss_hold();
    test_game_over();
    test_enable_freeze();
    test_clear_vs_tick();
    test_reset_in_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
